// File: rtl/imm_extender_if.sv
// Decode-side bus of the immediate extender: raw field, mode, handshakes,
// flush and the registered result. The master is the decode stage or the
// bench; the slave is the extender.
interface imm_extender_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] In;
  logic [1:0]       Mode;
  logic             InValid;
  logic             InReady;
  logic             Flush;
  logic [WIDTH-1:0] Out;
  logic             OutValid;
  logic             OutReady;
  logic             PrefixPending;

  modport master (
    output In, Mode, InValid, Flush, OutReady,
    input  InReady, Out, OutValid, PrefixPending
  );

  modport slave (
    input  In, Mode, InValid, Flush, OutReady,
    output InReady, Out, OutValid, PrefixPending
  );
endinterface

// File: rtl/imm_extender.sv
// Pipelined immediate extender for the MERC-16 datapath. Zero/sign/upper
// placement of In[FIELD_MSB:0] into a WIDTH-bit immediate, with a prefix
// register that can supply the high bits of the next immediate. One output
// register stage with a valid/ready handshake.
module imm_extender #(
  parameter int WIDTH     = 16,
  parameter int FIELD_MSB = 3
) (
  input  logic          Clock,
  input  logic          Reset_n,
  imm_extender_if.slave bus
);
  localparam int PREFIX_BITS = WIDTH - (FIELD_MSB + 1);
  localparam int USED_MSB    = (PREFIX_BITS - 1 > FIELD_MSB) ? PREFIX_BITS - 1 : FIELD_MSB;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'b00,
    MODE_SIGN   = 2'b01,
    MODE_PREFIX = 2'b10,
    MODE_UPPER  = 2'b11
  } mode_e;

  typedef enum logic {OUT_EMPTY, OUT_FULL}      out_state_e;
  typedef enum logic {PFX_IDLE,  PFX_PENDING}   pfx_state_e;

  out_state_e out_state, out_next;
  pfx_state_e pfx_state, pfx_next;

  logic [WIDTH-1:0]       out_q;
  logic [PREFIX_BITS-1:0] prefix_q;
  logic [WIDTH-1:0]       result;
  logic [FIELD_MSB:0]     field;
  mode_e                  mode;
  logic                   accept;
  logic                   is_prefix_op;
  logic                   produce;

  // Field bits above both the immediate field and the prefix slice are
  // never looked at; fold them into a named sink so intent is explicit.
  if (USED_MSB < WIDTH - 1) begin : g_unused
    logic unused_in_bits;
    assign unused_in_bits = ^bus.In[WIDTH-1:USED_MSB+1];
  end

  assign mode         = mode_e'(bus.Mode);
  assign field        = bus.In[FIELD_MSB:0];
  assign bus.InReady  = !bus.Flush && ((out_state == OUT_EMPTY) || bus.OutReady);
  assign accept       = bus.InValid && bus.InReady;
  assign is_prefix_op = (mode == MODE_PREFIX);
  assign produce      = accept && !is_prefix_op;

  assign bus.Out           = out_q;
  assign bus.OutValid      = (out_state == OUT_FULL);
  assign bus.PrefixPending = (pfx_state == PFX_PENDING);

  // Extension mux: a pending prefix replaces any zero/sign fill.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    result = '0;
    unique case (mode)
      MODE_ZERO, MODE_SIGN: begin
        if (pfx_state == PFX_PENDING)
          result = {prefix_q, field};
        else if (mode == MODE_SIGN)
          result = {{PREFIX_BITS{field[FIELD_MSB]}}, field};
        else
          result = {{PREFIX_BITS{1'b0}}, field};
      end
      MODE_UPPER:  result = {field, {PREFIX_BITS{1'b0}}};
      MODE_PREFIX: result = '0;
    endcase
  end

  // Next-state for the output slot and the prefix slot; flush wins.
  always_comb begin
    out_next = out_state;
    pfx_next = pfx_state;
    if (bus.Flush) begin
      out_next = OUT_EMPTY;
      pfx_next = PFX_IDLE;
    end else begin
      if (produce)
        out_next = OUT_FULL;
      else if (bus.OutReady)
        out_next = OUT_EMPTY;
      if (accept)
        pfx_next = is_prefix_op ? PFX_PENDING : PFX_IDLE;
    end
  end

  // State registers for both two-state resources.
  always_ff @(posedge Clock or negedge Reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block order.
    if (!Reset_n) begin
      out_state <= OUT_EMPTY;
      pfx_state <= PFX_IDLE;
    end else begin
      out_state <= out_next;
      pfx_state <= pfx_next;
    end
  end

  // Data registers: result on a producing accept, prefix on a prefix accept.
  always_ff @(posedge Clock or negedge Reset_n) begin
    // NOTE: data registers are reset too because Out must read 0 while in
    // reset; Flush leaves them alone since their contents are then unused.
    if (!Reset_n) begin
      out_q    <= '0;
      prefix_q <= '0;
    end else begin
      if (produce)
        out_q <= result;
      if (accept && is_prefix_op)
        prefix_q <= bus.In[PREFIX_BITS-1:0];
    end
  end
endmodule

// File: tb/tb_imm_extender.sv
// Directed bench for imm_extender: default 16/3 instance plus a 32/11
// instance for the parameter sweep. Expected values are hand-computed.
module tb_imm_extender;
  logic Clock;
  logic Reset_n;

  imm_extender_if #(.WIDTH(16)) bus16 ();
  imm_extender_if #(.WIDTH(32)) bus32 ();

  imm_extender #(.WIDTH(16), .FIELD_MSB(3)) dut16 (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus16.slave)
  );

  imm_extender #(.WIDTH(32), .FIELD_MSB(11)) dut32 (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus32.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one op on the 16-bit bus for one edge, then drop InValid.
  task automatic send16(input logic [1:0] m, input logic [15:0] d);
    bus16.Mode    = m;
    bus16.In      = d;
    bus16.InValid = 1'b1;
    @(posedge Clock); #1;
    bus16.InValid = 1'b0;
  endtask

  task automatic send32(input logic [1:0] m, input logic [31:0] d);
    bus32.Mode    = m;
    bus32.In      = d;
    bus32.InValid = 1'b1;
    @(posedge Clock); #1;
    bus32.InValid = 1'b0;
  endtask

  task automatic tick;
    @(posedge Clock); #1;
  endtask

  initial begin
    Reset_n        = 1'b0;
    bus16.In       = '0;
    bus16.Mode     = 2'b00;
    bus16.InValid  = 1'b0;
    bus16.Flush    = 1'b0;
    bus16.OutReady = 1'b1;
    bus32.In       = '0;
    bus32.Mode     = 2'b00;
    bus32.InValid  = 1'b0;
    bus32.Flush    = 1'b0;
    bus32.OutReady = 1'b1;

    // Reset state
    #12;
    check("rst_out",   32'(bus16.Out), 32'h0);
    check("rst_valid", 32'(bus16.OutValid), 32'h0);
    check("rst_pp",    32'(bus16.PrefixPending), 32'h0);
    @(negedge Clock) Reset_n = 1'b1;
    tick();
    check("rst_inready", 32'(bus16.InReady), 32'h1);

    // Defaults
    send16(2'b00, 16'hABCD);
    check("zero_out",   32'(bus16.Out), 32'h000D);
    check("zero_valid", 32'(bus16.OutValid), 32'h1);
    send16(2'b01, 16'h000A);
    check("sign_out",   32'(bus16.Out), 32'hFFFA);
    check("sign_valid", 32'(bus16.OutValid), 32'h1);
    send16(2'b01, 16'h0005);
    check("sign_pos_out", 32'(bus16.Out), 32'h0005);
    tick();
    check("drain_valid", 32'(bus16.OutValid), 32'h0);

    // Prefix chain
    send16(2'b10, 16'h0123);
    check("pfx_pp_set",   32'(bus16.PrefixPending), 32'h1);
    check("pfx_no_valid", 32'(bus16.OutValid), 32'h0);
    send16(2'b01, 16'h000F);
    check("pfx_out",      32'(bus16.Out), 32'h123F);
    check("pfx_pp_clr",   32'(bus16.PrefixPending), 32'h0);
    check("pfx_valid",    32'(bus16.OutValid), 32'h1);

    // Prefix overwrite then upper/discard
    send16(2'b10, 16'h0AAA);
    check("pfx_drain_valid", 32'(bus16.OutValid), 32'h0);
    send16(2'b10, 16'h0FFF);
    check("pfx2_pp", 32'(bus16.PrefixPending), 32'h1);
    send16(2'b11, 16'h0005);
    check("upper_out", 32'(bus16.Out), 32'h5000);
    check("upper_pp",  32'(bus16.PrefixPending), 32'h0);
    send16(2'b00, 16'h0002);
    check("after_discard_out", 32'(bus16.Out), 32'h0002);

    // Overwritten prefix: second prefix wins
    send16(2'b10, 16'h0111);
    send16(2'b10, 16'h0777);
    send16(2'b00, 16'h0003);
    check("pfx_overwrite_out", 32'(bus16.Out), 32'h7773);
    tick();

    // Backpressure
    bus16.OutReady = 1'b0;
    send16(2'b00, 16'h0007);
    check("bp_first", 32'(bus16.Out), 32'h0007);
    bus16.Mode    = 2'b00;
    bus16.In      = 16'h0009;
    bus16.InValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_inready", 32'(bus16.InReady), 32'h0);
      check("bp_out",     32'(bus16.Out), 32'h0007);
      check("bp_valid",   32'(bus16.OutValid), 32'h1);
      tick();
    end
    bus16.OutReady = 1'b1;
    #1;
    check("bp_release_inready", 32'(bus16.InReady), 32'h1);
    tick();
    check("b2b_0", 32'(bus16.Out), 32'h0009);
    bus16.In = 16'h000A;
    tick();
    check("b2b_1", 32'(bus16.Out), 32'h000A);
    check("b2b_1_valid", 32'(bus16.OutValid), 32'h1);
    bus16.In = 16'h000B;
    tick();
    check("b2b_2", 32'(bus16.Out), 32'h000B);
    bus16.InValid = 1'b0;
    tick();
    check("b2b_drained", 32'(bus16.OutValid), 32'h0);

    // Flush with prefix pending: input that cycle is dropped
    send16(2'b10, 16'h0456);
    check("fl_pp_before", 32'(bus16.PrefixPending), 32'h1);
    bus16.Flush   = 1'b1;
    bus16.Mode    = 2'b00;
    bus16.In      = 16'h0001;
    bus16.InValid = 1'b1;
    #1;
    check("fl_inready", 32'(bus16.InReady), 32'h0);
    tick();
    bus16.Flush   = 1'b0;
    bus16.InValid = 1'b0;
    check("fl_pp",    32'(bus16.PrefixPending), 32'h0);
    check("fl_valid", 32'(bus16.OutValid), 32'h0);
    send16(2'b00, 16'h0004);
    check("fl_after_out", 32'(bus16.Out), 32'h0004);

    // Flush with a stalled result
    bus16.OutReady = 1'b0;
    bus16.Flush    = 1'b1;
    bus16.Mode     = 2'b10;
    bus16.In       = 16'h0321;
    bus16.InValid  = 1'b1;
    tick();
    bus16.Flush    = 1'b0;
    bus16.InValid  = 1'b0;
    check("fl2_valid", 32'(bus16.OutValid), 32'h0);
    check("fl2_pp",    32'(bus16.PrefixPending), 32'h0);

    // Async reset mid-operation
    send16(2'b00, 16'h0008);
    check("ar_before", 32'(bus16.Out), 32'h0008);
    #2 Reset_n = 1'b0;
    #1;
    check("ar_out",   32'(bus16.Out), 32'h0);
    check("ar_valid", 32'(bus16.OutValid), 32'h0);
    @(negedge Clock) Reset_n = 1'b1;
    bus16.OutReady = 1'b1;
    tick();
    check("ar_inready", 32'(bus16.InReady), 32'h1);

    // Parameter sweep: WIDTH=32, FIELD_MSB=11
    send32(2'b01, 32'h0000_0800);
    check("w32_sign", bus32.Out, 32'hFFFF_F800);
    send32(2'b10, 32'h000A_BCDE);
    check("w32_pp", 32'(bus32.PrefixPending), 32'h1);
    send32(2'b00, 32'h0000_0123);
    check("w32_pfx", bus32.Out, 32'hABCD_E123);
    send32(2'b11, 32'h0000_0ABC);
    check("w32_upper", bus32.Out, 32'hABC0_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
